// File: rtl/nibble_serial_adder.sv
// nibble_serial_adder: WIDTH-bit unsigned adder that reuses one 4-bit
// ripple-carry slice, one nibble per clock, under a start/busy/done handshake.
// Optional feature macro: NIBBLE_SERIAL_ADDER_OVERFLOW_EN (adds the ovf port).
module nibble_serial_adder #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] in1,
  input  logic [WIDTH-1:0] in2,
  input  logic             c_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             c_out
`ifdef NIBBLE_SERIAL_ADDER_OVERFLOW_EN
  ,
  output logic             ovf
`endif
);

  localparam int unsigned NIB = WIDTH / 4;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           state_q;
  state_t           state_d;
  logic             busy_d;
  logic             done_d;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic             carry_q;
  logic [CNT_W-1:0] cnt_q;
  logic [3:0]       a_nib;
  logic [3:0]       b_nib;
  logic [4:0]       slice;
  logic [WIDTH-1:0] sum_upd;
  logic             accept;
  logic             last_nib;

  assign accept   = (state_q == S_IDLE) && start;
  assign last_nib = (cnt_q == CNT_W'(NIB - 1));

  // The shared 4-bit ripple-carry slice.
  assign slice = 5'(a_nib) + 5'(b_nib) + 5'(carry_q);

  // State register; busy/done are flopped from the next state so they are glitch-free.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      state_q <= state_d;
      busy    <= busy_d;
      done    <= done_d;
    end
  end

  // Next-state logic: start only matters in IDLE, DONE lasts one cycle.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start) state_d = S_RUN;
      S_RUN:   if (last_nib) state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Output decode of the upcoming state, registered in the state register block.
  always_comb begin
    busy_d = 1'b0;
    done_d = 1'b0;
    busy_d = (state_d == S_RUN);
    done_d = (state_d == S_DONE);
  end

  // Select the current nibble of each latched operand.
  always_comb begin
    a_nib = '0;
    b_nib = '0;
    for (int i = 0; i < int'(NIB); i++) begin
      if (cnt_q == CNT_W'(i)) begin
        a_nib = a_q[4*i +: 4];
        b_nib = b_q[4*i +: 4];
      end
    end
  end

  // Merge the slice sum into the current nibble position of the result.
  always_comb begin
    sum_upd = sum;
    for (int i = 0; i < int'(NIB); i++) begin
      if (cnt_q == CNT_W'(i)) sum_upd[4*i +: 4] = slice[3:0];
    end
  end

  // Datapath registers: operand capture on accept, nibble-by-nibble accumulation in RUN.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_q     <= '0;
      b_q     <= '0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
      sum     <= '0;
      c_out   <= 1'b0;
`ifdef NIBBLE_SERIAL_ADDER_OVERFLOW_EN
      ovf     <= 1'b0;
`endif
    end else if (accept) begin
      a_q     <= in1;
      b_q     <= in2;
      carry_q <= c_in;
      cnt_q   <= '0;
      sum     <= '0;
      c_out   <= 1'b0;
`ifdef NIBBLE_SERIAL_ADDER_OVERFLOW_EN
      ovf     <= 1'b0;
`endif
    end else if (state_q == S_RUN) begin
      sum     <= sum_upd;
      carry_q <= slice[4];
      cnt_q   <= cnt_q + CNT_W'(1);
      if (last_nib) begin
        c_out <= slice[4];
`ifdef NIBBLE_SERIAL_ADDER_OVERFLOW_EN
        // carry into the MSB is recovered from its sum bit: a ^ b ^ s
        ovf   <= a_nib[3] ^ b_nib[3] ^ slice[3] ^ slice[4];
`endif
      end
    end
  end

endmodule

// File: tb/tb_nibble_serial_adder.sv
// Self-checking bench for nibble_serial_adder: directed cases plus random
// operands compared against plain full-width arithmetic.
module tb_nibble_serial_adder;

  localparam int unsigned W   = 16;
  localparam int unsigned NIB = W / 4;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [W-1:0] in1;
  logic [W-1:0] in2;
  logic         c_in;
  logic         busy;
  logic         done;
  logic [W-1:0] sum;
  logic         c_out;
`ifdef NIBBLE_SERIAL_ADDER_OVERFLOW_EN
  logic         ovf;
`endif

  int n_vec = 0;
  int n_err = 0;

  nibble_serial_adder #(.WIDTH(W), .CNT_W(4)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .in1   (in1),
    .in2   (in2),
    .c_in  (c_in),
    .busy  (busy),
    .done  (done),
    .sum   (sum),
    .c_out (c_out)
`ifdef NIBBLE_SERIAL_ADDER_OVERFLOW_EN
    ,
    .ovf   (ovf)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
    end
  endtask

  // One transaction; spur_at > 0 raises start with junk operands after that cycle's sample.
  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic ci,
                        input int spur_at);
    logic [W:0] full;
    logic       exp_ovf;
    full    = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, ci};
    exp_ovf = (a[W-1] == b[W-1]) && (full[W-1] != a[W-1]);
    @(negedge clk);
    start = 1'b1;
    in1   = a;
    in2   = b;
    c_in  = ci;
    @(posedge clk);
    #1;
    start = 1'b0;
    in1   = W'($urandom);
    in2   = W'($urandom);
    c_in  = 1'($urandom);
    for (int c = 1; c <= int'(NIB) + 1; c++) begin
      @(negedge clk);
      if (c <= int'(NIB)) begin
        check("busy_run", 32'(busy), 32'd1);
        check("done_run", 32'(done), 32'd0);
      end else begin
        check("busy_done", 32'(busy), 32'd0);
        check("done_pulse", 32'(done), 32'd1);
        check("sum", 32'(sum), 32'(full[W-1:0]));
        check("c_out", 32'(c_out), 32'(full[W]));
`ifdef NIBBLE_SERIAL_ADDER_OVERFLOW_EN
        check("ovf", 32'(ovf), 32'(exp_ovf));
`endif
      end
      if (c == spur_at) begin
        start = 1'b1;
        in1   = '1;
        in2   = '1;
        c_in  = 1'b1;
      end else begin
        start = 1'b0;
      end
    end
    @(negedge clk);
    start = 1'b0;
    check("done_end", 32'(done), 32'd0);
    check("busy_end", 32'(busy), 32'd0);
    @(negedge clk);
    check("sum_hold", 32'(sum), 32'(full[W-1:0]));
    check("c_out_hold", 32'(c_out), 32'(full[W]));
  endtask

  initial begin
    rst   = 1'b1;
    start = 1'b0;
    in1   = '0;
    in2   = '0;
    c_in  = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_sum", 32'(sum), 32'd0);
    check("rst_c_out", 32'(c_out), 32'd0);
    rst = 1'b0;

    // idle without start stays idle
    repeat (3) @(negedge clk);
    check("idle_busy", 32'(busy), 32'd0);
    check("idle_done", 32'(done), 32'd0);

    run_op(16'h1234, 16'h4321, 1'b0, 0);
    run_op(16'hFFFF, 16'h0001, 1'b0, 0);
    run_op(16'h00FF, 16'h0000, 1'b1, 0);
    run_op(16'h0404, 16'h0C04, 1'b0, 0);
    // start during RUN and during DONE must be ignored
    run_op(16'h1111, 16'h1111, 1'b0, 2);
    run_op(16'h0F0F, 16'hF0F1, 1'b1, int'(NIB) + 1);

    // reset in the 2nd RUN cycle aborts
    @(negedge clk);
    start = 1'b1;
    in1   = 16'hAAAA;
    in2   = 16'h5555;
    c_in  = 1'b0;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_done", 32'(done), 32'd0);
    check("abort_sum", 32'(sum), 32'd0);
    check("abort_c_out", 32'(c_out), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < int'(NIB) + 2; i++) begin
      @(negedge clk);
      check("abort_no_done", 32'(done), 32'd0);
    end
    run_op(16'h0001, 16'h0001, 1'b0, 0);

`ifdef NIBBLE_SERIAL_ADDER_OVERFLOW_EN
    run_op(16'h7FFF, 16'h0001, 1'b0, 0);
    run_op(16'hFFFF, 16'h0001, 1'b0, 0);
    run_op(16'h8000, 16'h8000, 1'b0, 0);
`endif

    for (int i = 0; i < 25; i++) begin
      run_op(W'($urandom), W'($urandom), 1'($urandom),
             int'($urandom_range(0, NIB + 1)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
